// File: rtl/wb_pc_unit_if.sv
// wb_pc_unit_if: bundle of every signal between the write-back / next-PC
// stage and its neighbours (execute/memory, UART receiver, fetch, register file).
// The master modport is the upstream side that drives instructions and operands.
// The slave modport is the wb_pc_unit itself.
// The parameters must match the ones given to the wb_pc_unit that uses this bundle.
interface wb_pc_unit_if #(
  parameter int INST_MEM_WIDTH = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_W     = 5
);

  logic                      in_valid;
  logic                      in_ready;
  logic                      AorF;
  logic                      RegWrite;
  logic [1:0]                MemtoReg;
  logic [1:0]                Branch;
  logic                      JumpReg;
  logic [DATA_WIDTH-1:0]     alu_result;
  logic [DATA_WIDTH-1:0]     register_data;
  logic [DATA_WIDTH-1:0]     read_data;
  logic                      mem_ready;
  logic [REG_ADDR_W-1:0]     rd;
  logic [25:0]               inst_index;
  logic [INST_MEM_WIDTH-1:0] pc1;
  logic [INST_MEM_WIDTH-1:0] pc2;
  logic                      input_valid;
  logic [DATA_WIDTH-1:0]     input_data;
  logic                      input_ack;
  logic                      out_valid;
  logic                      AorF_next;
  logic                      RegWrite_next;
  logic [REG_ADDR_W-1:0]     rd_next;
  logic [DATA_WIDTH-1:0]     data;
  logic [INST_MEM_WIDTH-1:0] pc_next;
  logic [INST_MEM_WIDTH-1:0] pc1_next;
  logic                      timeout_err;

  modport master (
    output in_valid, AorF, RegWrite, MemtoReg, Branch, JumpReg,
           alu_result, register_data, read_data, mem_ready, rd, inst_index,
           pc1, pc2, input_valid, input_data,
    input  in_ready, input_ack, out_valid, AorF_next, RegWrite_next, rd_next,
           data, pc_next, pc1_next, timeout_err
  );

  modport slave (
    input  in_valid, AorF, RegWrite, MemtoReg, Branch, JumpReg,
           alu_result, register_data, read_data, mem_ready, rd, inst_index,
           pc1, pc2, input_valid, input_data,
    output in_ready, input_ack, out_valid, AorF_next, RegWrite_next, rd_next,
           data, pc_next, pc1_next, timeout_err
  );

endinterface

// File: rtl/wb_pc_unit.sv
// wb_pc_unit: write-back source select and next-PC resolution for the multi-cycle core.
// The stage takes one instruction per handshake, waits for memory or UART data
// if needed, and then gives a single commit pulse. That pulse restarts fetch and
// writes the register file.
// Optional feature: define WB_UART_TIMEOUT_EN to abandon a UART read after
// UART_TIMEOUT idle cycles. A timed-out read commits data=0 with the write
// disabled and sets the sticky timeout_err flag.
module wb_pc_unit #(
  parameter int INST_MEM_WIDTH = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int UART_TIMEOUT   = 1024
) (
  input  logic         CLK,
  input  logic         reset,
  wb_pc_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    WAIT_MEM,
    WAIT_IN,
    COMMIT
  } state_t;

  state_t                    state;

  // Instruction fields captured on acceptance. Upstream may change its
  // outputs freely after the handshake.
  logic                      cap_aorf;
  logic                      cap_regwrite;
  logic                      cap_jumpreg;
  logic [1:0]                cap_branch;
  logic                      cap_alu_zero;
  logic [REG_ADDR_W-1:0]     cap_rd;
  logic [INST_MEM_WIDTH-1:0] cap_reg_target;
  logic [INST_MEM_WIDTH-1:0] cap_jump_target;
  logic [INST_MEM_WIDTH-1:0] cap_pc1;
  logic [INST_MEM_WIDTH-1:0] cap_pc2;
  logic [DATA_WIDTH-1:0]     wb_data;

  logic [DATA_WIDTH-1:0]     link_data;
  logic [INST_MEM_WIDTH-1:0] target_pc;
  logic                      branch_taken;
  logic                      timeout_hit;

  // Only the low bits of the jump sources form a PC. The remaining bits are
  // collected here so that leaving them unused is clearly intentional.
  logic                      unused_sink;
  assign unused_sink = ^{bus.inst_index, bus.register_data, UART_TIMEOUT};

  // Link value: pc1 zero-extended to the data width.
  always_comb begin
    link_data = '0;
    link_data[INST_MEM_WIDTH-1:0] = bus.pc1;
  end

  // Next PC from the captured fields. JumpReg takes priority over every Branch
  // code; conditional branches test the captured ALU zero flag.
  always_comb begin
    branch_taken = (cap_branch == 2'b00) ? cap_alu_zero : !cap_alu_zero;
    target_pc    = cap_pc1;
    if (cap_jumpreg) begin
      target_pc = cap_reg_target;
    end else begin
      case (cap_branch)
        2'b10:        target_pc = cap_jump_target;
        2'b00, 2'b01: target_pc = branch_taken ? cap_pc2 : cap_pc1;
        default:      target_pc = cap_pc1;
      endcase
    end
  end

  // The UART acknowledge is combinational. It echoes input_valid in exactly the
  // cycle in which the word is consumed.
  assign bus.input_ack = !reset && (state == WAIT_IN) && bus.input_valid;

`ifdef WB_UART_TIMEOUT_EN
  localparam int TO_W = $clog2(UART_TIMEOUT + 1);

  logic [TO_W-1:0] wait_cnt;
  logic            timeout_flag;

  assign timeout_hit = (state == WAIT_IN) && !bus.input_valid &&
                       (wait_cnt == TO_W'(UART_TIMEOUT - 1));
  assign bus.timeout_err = timeout_flag;

  // Count idle cycles spent in WAIT_IN. WAIT_IN is entered only from IDLE, so
  // the counter is cleared there. The error flag stays set until reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == IDLE) begin
        wait_cnt <= '0;
      end else if ((state == WAIT_IN) && !bus.input_valid) begin
        wait_cnt <= wait_cnt + TO_W'(1);
      end
      if (timeout_hit) begin
        timeout_flag <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Main control FSM. It captures on accept, waits for late data, and then
  // registers all commit outputs together with a one-cycle out_valid pulse.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state             <= BOOT;
      bus.in_ready      <= 1'b0;
      bus.out_valid     <= 1'b0;
      bus.AorF_next     <= 1'b0;
      bus.RegWrite_next <= 1'b0;
      bus.rd_next       <= '0;
      bus.data          <= '0;
      bus.pc_next       <= '0;
      bus.pc1_next      <= INST_MEM_WIDTH'(1);
      cap_aorf          <= 1'b0;
      cap_regwrite      <= 1'b0;
      cap_jumpreg       <= 1'b0;
      cap_branch        <= 2'b10;
      cap_alu_zero      <= 1'b0;
      cap_rd            <= '0;
      cap_reg_target    <= '0;
      cap_jump_target   <= '0;
      cap_pc1           <= '0;
      cap_pc2           <= '0;
      wb_data           <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        BOOT: begin
          // Fake a non-writing jump to address 0 so the first commit starts fetch.
          cap_aorf        <= 1'b0;
          cap_regwrite    <= 1'b0;
          cap_jumpreg     <= 1'b0;
          cap_branch      <= 2'b10;
          cap_jump_target <= '0;
          cap_rd          <= '0;
          wb_data         <= '0;
          state           <= COMMIT;
        end
        IDLE: begin
          if (bus.in_valid) begin
            cap_aorf        <= bus.AorF;
            cap_regwrite    <= bus.RegWrite;
            cap_jumpreg     <= bus.JumpReg;
            cap_branch      <= bus.Branch;
            cap_alu_zero    <= (bus.alu_result == '0);
            cap_rd          <= bus.rd;
            cap_reg_target  <= bus.register_data[INST_MEM_WIDTH-1:0];
            cap_jump_target <= bus.inst_index[INST_MEM_WIDTH-1:0];
            cap_pc1         <= bus.pc1;
            cap_pc2         <= bus.pc2;
            bus.in_ready    <= 1'b0;
            case (bus.MemtoReg)
              2'b00:   wb_data <= bus.alu_result;
              2'b10:   wb_data <= link_data;
              default: wb_data <= '0;
            endcase
            case (bus.MemtoReg)
              2'b01:   state <= WAIT_MEM;
              2'b11:   state <= WAIT_IN;
              default: state <= COMMIT;
            endcase
          end
        end
        WAIT_MEM: begin
          if (bus.mem_ready) begin
            wb_data <= bus.read_data;
            state   <= COMMIT;
          end
        end
        WAIT_IN: begin
          if (bus.input_valid) begin
            wb_data <= bus.input_data;
            state   <= COMMIT;
          end else if (timeout_hit) begin
            wb_data      <= '0;
            cap_regwrite <= 1'b0;
            state        <= COMMIT;
          end
        end
        COMMIT: begin
          bus.AorF_next     <= cap_aorf;
          bus.RegWrite_next <= cap_regwrite;
          bus.rd_next       <= cap_rd;
          bus.data          <= wb_data;
          bus.pc_next       <= target_pc;
          bus.pc1_next      <= target_pc + INST_MEM_WIDTH'(1);
          bus.out_valid     <= 1'b1;
          bus.in_ready      <= 1'b1;
          state             <= IDLE;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_pc_unit.sv
// tb_wb_pc_unit: randomized, self-checking bench for wb_pc_unit.
// Each instruction is described at transaction level. Expected commit values
// and latencies come from plain arithmetic on the instruction fields.
// Build with WB_UART_TIMEOUT_EN defined to also exercise the UART timeout.
module tb_wb_pc_unit;

  localparam int IMW        = 5;
  localparam int DW         = 32;
  localparam int RW         = 5;
  localparam int TB_TIMEOUT = 8;
  localparam int PC_SPAN    = 1 << IMW;
`ifdef WB_UART_TIMEOUT_EN
  localparam int UART_LATE      = 5;
  localparam int UART_MAX_DELAY = 6;
`else
  localparam int UART_LATE      = 10;
  localparam int UART_MAX_DELAY = 12;
`endif

  typedef struct {
    logic        aorf;
    logic        regwrite;
    logic        jumpreg;
    logic [1:0]  memtoreg;
    logic [1:0]  branch;
    logic [31:0] alu;
    logic [31:0] regdata;
    logic [31:0] mem_val;
    logic [31:0] uart_val;
    logic [4:0]  rd;
    logic [4:0]  pc1;
    logic [4:0]  pc2;
    logic [25:0] inst_index;
    int          delay;
  } txn_t;

  logic CLK;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic exp_timeout_err;

  wb_pc_unit_if #(.INST_MEM_WIDTH(IMW), .DATA_WIDTH(DW), .REG_ADDR_W(RW)) bus ();

  wb_pc_unit #(
    .INST_MEM_WIDTH(IMW),
    .DATA_WIDTH(DW),
    .REG_ADDR_W(RW),
    .UART_TIMEOUT(TB_TIMEOUT)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard stop in case the bench itself loses its way.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic txn_t mkTxn();
    txn_t t;
    t.aorf = 1'b0; t.regwrite = 1'b1; t.jumpreg = 1'b0;
    t.memtoreg = 2'b00; t.branch = 2'b11;
    t.alu = 32'h0; t.regdata = 32'h0; t.mem_val = 32'h0; t.uart_val = 32'h0;
    t.rd = 5'd0; t.pc1 = 5'd1; t.pc2 = 5'd0; t.inst_index = 26'h0; t.delay = 0;
    return t;
  endfunction

  function automatic txn_t randTxn();
    txn_t t;
    t.aorf       = 1'($urandom);
    t.regwrite   = 1'($urandom);
    t.jumpreg    = ($urandom_range(0, 3) == 0);
    t.memtoreg   = 2'($urandom);
    t.branch     = 2'($urandom);
    t.alu        = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
    t.regdata    = $urandom;
    t.mem_val    = $urandom;
    t.uart_val   = $urandom;
    t.rd         = 5'($urandom);
    t.pc1        = 5'($urandom);
    t.pc2        = 5'($urandom);
    t.inst_index = 26'($urandom);
    t.delay      = (t.memtoreg == 2'b11) ? int'($urandom_range(0, UART_MAX_DELAY))
                                         : int'($urandom_range(0, 4));
    return t;
  endfunction

  function automatic bit modelTimesOut(input txn_t t);
`ifdef WB_UART_TIMEOUT_EN
    return (t.memtoreg == 2'b11) && (t.delay >= TB_TIMEOUT);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned modelPc(input txn_t t);
    int unsigned target;
    if (t.jumpreg)               target = t.regdata % PC_SPAN;
    else if (t.branch == 2'b10)  target = t.inst_index % PC_SPAN;
    else if (t.branch == 2'b00)  target = (t.alu == 0) ? t.pc2 : t.pc1;
    else if (t.branch == 2'b01)  target = (t.alu != 0) ? t.pc2 : t.pc1;
    else                         target = t.pc1;
    return target;
  endfunction

  function automatic logic [31:0] modelData(input txn_t t);
    case (t.memtoreg)
      2'b00:   return t.alu;
      2'b01:   return t.mem_val;
      2'b10:   return {27'h0, t.pc1};
      default: return modelTimesOut(t) ? 32'h0 : t.uart_val;
    endcase
  endfunction

  function automatic int modelLatency(input txn_t t);
    if (modelTimesOut(t))                              return TB_TIMEOUT + 2;
    if (t.memtoreg == 2'b01 || t.memtoreg == 2'b11)    return t.delay + 3;
    return 2;
  endfunction

  task automatic driveFields(input txn_t t);
    bus.AorF = t.aorf; bus.RegWrite = t.regwrite; bus.JumpReg = t.jumpreg;
    bus.MemtoReg = t.memtoreg; bus.Branch = t.branch;
    bus.alu_result = t.alu; bus.register_data = t.regdata;
    bus.rd = t.rd; bus.pc1 = t.pc1; bus.pc2 = t.pc2; bus.inst_index = t.inst_index;
  endtask

  task automatic scrambleFields();
    bus.AorF = 1'($urandom); bus.RegWrite = 1'($urandom); bus.JumpReg = 1'($urandom);
    bus.MemtoReg = 2'($urandom); bus.Branch = 2'($urandom);
    bus.alu_result = $urandom; bus.register_data = $urandom;
    bus.rd = 5'($urandom); bus.pc1 = 5'($urandom); bus.pc2 = 5'($urandom);
    bus.inst_index = 26'($urandom);
  endtask

  task automatic doReset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_in_ready", bus.in_ready, 1'b0);
    checkOutput("rst_pc_next", bus.pc_next, 5'd0);
    checkOutput("rst_pc1_next", bus.pc1_next, 5'd1);
    checkOutput("rst_data", bus.data, 32'h0);
    checkOutput("rst_regwrite", bus.RegWrite_next, 1'b0);
    checkOutput("rst_timeout_err", bus.timeout_err, 1'b0);
    exp_timeout_err = 1'b0;
    reset = 1'b0;
    @(posedge CLK); @(negedge CLK);
    checkOutput("boot_cycle1_out_valid", bus.out_valid, 1'b0);
    @(posedge CLK); @(negedge CLK);
    checkOutput("boot_out_valid", bus.out_valid, 1'b1);
    checkOutput("boot_pc_next", bus.pc_next, 5'd0);
    checkOutput("boot_pc1_next", bus.pc1_next, 5'd1);
    checkOutput("boot_regwrite", bus.RegWrite_next, 1'b0);
    checkOutput("boot_in_ready", bus.in_ready, 1'b1);
  endtask

  // Issues one instruction, services its memory/UART wait, and checks the commit.
  task automatic applyStimulus(input txn_t t, input string name);
    int          waitc;
    int          edges;
    int          acks;
    int          ready_bad;
    int unsigned e_pc;
    waitc = 0;
    while (!bus.in_ready && waitc < 20) begin
      @(posedge CLK); @(negedge CLK);
      waitc++;
    end
    checkOutput({name, "_accept_ready"}, bus.in_ready, 1'b1);
    driveFields(t);
    bus.in_valid = 1'b1;
    bus.mem_ready = 1'b0;
    bus.input_valid = 1'b0;
    @(posedge CLK); @(negedge CLK);
    scrambleFields();
    edges = 1; acks = 0; ready_bad = 0;
    while (!bus.out_valid && edges < 1100) begin
      bus.in_valid    = 1'($urandom);
      bus.mem_ready   = (t.memtoreg == 2'b01) ? (edges - 1 >= t.delay) : 1'($urandom);
      bus.read_data   = (t.memtoreg == 2'b01 && edges - 1 >= t.delay) ? t.mem_val : $urandom;
      bus.input_valid = (t.memtoreg == 2'b11) ? (edges - 1 >= t.delay) : 1'($urandom);
      bus.input_data  = (t.memtoreg == 2'b11 && edges - 1 >= t.delay) ? t.uart_val : $urandom;
      #1;
      if (bus.input_ack) acks++;
      if (bus.in_ready) ready_bad++;
      @(posedge CLK); @(negedge CLK);
      edges++;
    end
    bus.in_valid = 1'b0;
    bus.mem_ready = 1'b0;
    bus.input_valid = 1'b0;
    if (modelTimesOut(t)) exp_timeout_err = 1'b1;
    e_pc = modelPc(t);
    checkOutput({name, "_out_valid"}, bus.out_valid, 1'b1);
    checkOutput({name, "_latency"}, edges, modelLatency(t));
    checkOutput({name, "_data"}, bus.data, modelData(t));
    checkOutput({name, "_rd_next"}, bus.rd_next, t.rd);
    checkOutput({name, "_aorf_next"}, bus.AorF_next, t.aorf);
    checkOutput({name, "_regwrite_next"}, bus.RegWrite_next, t.regwrite && !modelTimesOut(t));
    checkOutput({name, "_pc_next"}, bus.pc_next, e_pc);
    checkOutput({name, "_pc1_next"}, bus.pc1_next, (e_pc + 1) % PC_SPAN);
    checkOutput({name, "_in_ready_at_commit"}, bus.in_ready, 1'b1);
    checkOutput({name, "_busy_in_ready"}, ready_bad, 0);
    checkOutput({name, "_input_acks"}, acks,
                (t.memtoreg == 2'b11 && !modelTimesOut(t)) ? 1 : 0);
    checkOutput({name, "_timeout_err"}, bus.timeout_err, exp_timeout_err);
  endtask

  initial begin
    txn_t t;
    int   gap;
    reset = 1'b1;
    exp_timeout_err = 1'b0;
    bus.in_valid = 1'b0; bus.mem_ready = 1'b0; bus.input_valid = 1'b0;
    bus.read_data = 32'h0; bus.input_data = 32'h0;
    driveFields(mkTxn());
    $display("[TB] start");

    doReset();

    t = mkTxn(); t.alu = 32'h1234; t.rd = 5'd7; t.pc1 = 5'd3;
    applyStimulus(t, "alu_write");

    t = mkTxn(); t.branch = 2'b00; t.alu = 32'h0; t.pc1 = 5'd9; t.pc2 = 5'h1F;
    applyStimulus(t, "beq_taken_wrap");
    t.alu = 32'd5;
    applyStimulus(t, "beq_not_taken");

    t = mkTxn(); t.memtoreg = 2'b01; t.mem_val = 32'hDEADBEEF; t.delay = 3; t.rd = 5'd12;
    applyStimulus(t, "mem_load");

    t = mkTxn(); t.memtoreg = 2'b11; t.uart_val = 32'h41; t.delay = UART_LATE; t.rd = 5'd4;
    applyStimulus(t, "uart_read");

`ifdef WB_UART_TIMEOUT_EN
    t = mkTxn(); t.memtoreg = 2'b11; t.uart_val = 32'h55; t.delay = 5000; t.rd = 5'd9;
    applyStimulus(t, "uart_timeout");
    t = mkTxn(); t.alu = 32'h77; t.rd = 5'd2;
    applyStimulus(t, "after_timeout");
`endif

    // Abandon a load by resetting while it waits for memory.
    t = mkTxn(); t.memtoreg = 2'b01; t.mem_val = 32'hCAFEF00D; t.rd = 5'd30; t.pc1 = 5'd17;
    driveFields(t);
    bus.in_valid = 1'b1;
    @(posedge CLK); @(negedge CLK);
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge CLK); @(negedge CLK);
    end
    checkOutput("stall_no_commit", bus.out_valid, 1'b0);
    bus.mem_ready = 1'b1;
    bus.read_data = 32'hCAFEF00D;
    doReset();
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); @(negedge CLK);
      checkOutput("abandoned_out_valid", bus.out_valid, 1'b0);
      checkOutput("abandoned_data", bus.data, 32'h0);
    end
    bus.mem_ready = 1'b0;

    t = mkTxn(); t.jumpreg = 1'b1; t.branch = 2'b10; t.inst_index = 26'h5;
    t.regdata = 32'hFFFF_FF13; t.regwrite = 1'b0;
    applyStimulus(t, "jr");

    for (int n = 0; n < 60; n++) begin
      t = randTxn();
      applyStimulus(t, "rand");
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(posedge CLK); @(negedge CLK);
        checkOutput("hold_out_valid", bus.out_valid, 1'b0);
        checkOutput("hold_data", bus.data, modelData(t));
        checkOutput("hold_pc_next", bus.pc_next, modelPc(t));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
